// File: rtl/fb_writer.sv
// fb_writer: streams pixels into an external SRAM through a trigger/done
// controller handshake. Incoming pixels are buffered in a small FIFO and
// written one at a time at consecutive byte addresses. The address wraps
// at the end of the frame, and a start-of-frame pixel forces it back to 0.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous reset, active low
//   pix_valid   upstream pixel present
//   pix_data    pixel {blue[2:0], green[1:0], red[2:0]}, stored unchanged
//   pix_sof     pixel is the first of a frame (qualified by pix_valid)
//   pix_ready   pixel accepted this cycle when pix_valid is also high
//   trig_out    one-cycle write request to the SRAM controller
//   rw_out      transfer direction, always 0 (write)
//   addr_out    SRAM byte address of the current write
//   w_data_out  write data of the current write
//   done_in     one-cycle completion pulse from the SRAM controller
//   frame_done  one-cycle pulse after the last pixel of a frame is written
module fb_writer #(
    parameter int FRAME_PIXELS = 480000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic        trig_out,
    output logic        rw_out,
    output logic [18:0] addr_out,
    output logic [7:0]  w_data_out,
    input  logic        done_in,
    output logic        frame_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [18:0]   LAST_ADDR = 19'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // FIFO entries are {sof, pixel}
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop, fifo_empty;
    logic [8:0]    head;

    logic [18:0]   wptr;
    logic          wr_done;

    assign rw_out     = 1'b0;
    assign push       = pix_valid & pix_ready;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // pix_ready is its own register and is loaded from the next occupancy,
    // so it always equals "not full". It depends on no input
    // combinationally, and it stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pix_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            pix_ready <= (count_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pix_sof, pix_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ISSUE is entered only with a non-empty FIFO, so the pop is always legal.
    // done_in is only looked at in WAIT.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ISSUE;
            ISSUE: begin
                pop       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_in) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The write command is registered on the ISSUE->WAIT edge. trig_out is
    // therefore high for exactly the first WAIT cycle, and address/data stay
    // put until the next ISSUE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            trig_out   <= 1'b0;
            frame_done <= 1'b0;
            addr_out   <= '0;
            w_data_out <= '0;
            wptr       <= '0;
        end else begin
            trig_out   <= pop;
            frame_done <= wr_done && (addr_out == LAST_ADDR);
            if (pop) begin
                w_data_out <= head[7:0];
                addr_out   <= head[8] ? '0 : wptr;
            end
            if (wr_done) begin
                wptr <= (addr_out == LAST_ADDR) ? '0 : addr_out + 19'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer with FRAME_PIXELS = 8.
// A behavioural SRAM controller answers every trig_out with done_in after a
// programmable latency. It logs each write and keeps an 8-byte memory image.
module tb_fb_writer;

    localparam int FP = 8;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_sof = 1'b0;
    logic        done_in = 1'b0;
    logic        pix_ready, trig_out, rw_out, frame_done;
    logic [18:0] addr_out;
    logic [7:0]  w_data_out;

    fb_writer #(.FRAME_PIXELS(FP), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .trig_out(trig_out),
        .rw_out(rw_out), .addr_out(addr_out), .w_data_out(w_data_out),
        .done_in(done_in), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- SRAM controller model / monitor ----------------
    int          cyc = 0;
    int          done_cnt = 0;
    int          lat = 1;
    bit          hold_done = 1'b0;
    bit          rand_lat = 1'b0;
    bit          abandoned = 1'b0;
    bit          trig_prev = 1'b0;
    logic [18:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic [7:0]  mem [FP];
    int          fd_cnt = 0, fd_gap = -1, last_done_cyc = 0;
    logic [18:0] last_done_addr = '0, fd_addr = '0, wait_addr = '0;
    logic [7:0]  wait_data = '0;
    int          stable_err = 0, dbl_trig = 0;

    always @(negedge clk) begin
        cyc++;
        done_in = 1'b0;
        if (!rst) abandoned = 1'b1;
        if (frame_done) begin
            fd_cnt++;
            fd_gap  = cyc - last_done_cyc;
            fd_addr = last_done_addr;
        end
        if (trig_out && trig_prev) dbl_trig++;
        trig_prev = trig_out;
        if (done_cnt == 1 && !hold_done) begin
            done_in        = 1'b1;
            done_cnt       = 0;
            last_done_cyc  = cyc;
            last_done_addr = addr_out;
            if (!abandoned && (addr_out !== wait_addr || w_data_out !== wait_data))
                stable_err++;
        end else if (done_cnt > 1) begin
            done_cnt--;
        end
        if (trig_out) begin
            got_addr.push_back(addr_out);
            got_data.push_back(w_data_out);
            mem[addr_out[2:0]] = w_data_out;
            wait_addr = addr_out;
            wait_data = w_data_out;
            abandoned = 1'b0;
            done_cnt  = rand_lat ? int'($urandom_range(1, 10)) : lat;
        end
    end

    // ---------------- stimulus helpers (called on negedge) ----------------
    task automatic push(input logic [7:0] d, input logic s);
        int t = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        while (!pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) chk("push_timeout", 32'(pix_ready), 1);
        else @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (got_addr.size() < n && t < 800) begin
            @(negedge clk);
            t++;
        end
        if (got_addr.size() < n) chk("write_timeout", 32'(got_addr.size()), 32'(n));
        repeat (14) @(negedge clk);
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] exp_d [24];
    int         acc, fd0, n0;
    bit         rdy;

    initial begin
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(pix_ready), 0);
        chk("rst_trig",  32'(trig_out), 0);
        chk("rst_addr",  32'(addr_out), 0);
        chk("rst_data",  32'(w_data_out), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_rw",    32'(rw_out), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(pix_ready), 1);

        // single pixel, latency to trig, next address
        clear_log();
        lat = 3;
        push(8'hA5, 1'b1);
        chk("lat_trig_n", 32'(trig_out), 0);
        @(negedge clk);
        chk("lat_trig_n1", 32'(trig_out), 0);
        @(negedge clk);
        chk("lat_trig_n2", 32'(trig_out), 1);
        chk("a5_addr", 32'(addr_out), 0);
        chk("a5_data", 32'(w_data_out), 32'h A5);
        @(negedge clk);
        chk("trig_one_cycle", 32'(trig_out), 0);
        wait_writes(1);
        push(8'h3C, 1'b0);
        wait_writes(2);
        chk("next_addr", 32'(got_addr[1]), 1);
        chk("next_data", 32'(got_data[1]), 32'h3C);

        // backpressure: done withheld, valid held high
        clear_log();
        lat = 1;
        hold_done = 1'b1;
        acc = 0;
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = 8'h10;
        for (int c = 0; c < 20; c++) begin
            rdy = pix_ready;
            @(negedge clk);
            if (rdy) begin
                acc++;
                pix_data = 8'h10 + 8'(acc);
                pix_sof  = 1'b0;
            end
        end
        pix_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 5);
        chk("bp_ready_low", 32'(pix_ready), 0);
        chk("bp_one_inflight", 32'(got_addr.size()), 1);
        hold_done = 1'b0;
        wait_writes(5);
        for (int i = 0; i < 5; i++) begin
            chk("bp_addr", 32'(got_addr[i]), 32'(i));
            chk("bp_data", 32'(got_data[i]), 32'(8'h10 + 8'(i)));
        end

        // frame wrap with frame_done
        clear_log();
        fd0 = fd_cnt;
        for (int i = 0; i < 9; i++) push(8'h20 + 8'(i), i == 0);
        wait_writes(9);
        for (int i = 0; i < 9; i++) begin
            chk("wrap_addr", 32'(got_addr[i]), 32'(i % 8));
            chk("wrap_data", 32'(got_data[i]), 32'(8'h20 + 8'(i)));
        end
        chk("wrap_fd_count", 32'(fd_cnt - fd0), 1);
        chk("wrap_fd_gap", 32'(fd_gap), 1);
        chk("wrap_fd_addr", 32'(fd_addr), 7);

        // sof resync in mid-frame
        clear_log();
        fd0 = fd_cnt;
        push(8'h30, 1'b1);
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        push(8'h33, 1'b1);
        push(8'h34, 1'b0);
        wait_writes(5);
        chk("sof_a0", 32'(got_addr[0]), 0);
        chk("sof_a1", 32'(got_addr[1]), 1);
        chk("sof_a2", 32'(got_addr[2]), 2);
        chk("sof_a3", 32'(got_addr[3]), 0);
        chk("sof_a4", 32'(got_addr[4]), 1);
        chk("sof_d3", 32'(got_data[3]), 32'h33);
        chk("sof_no_fd", 32'(fd_cnt - fd0), 0);

        // reset during WAIT with two entries queued
        clear_log();
        push(8'h40, 1'b1);
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        wait_writes(3);
        hold_done = 1'b1;
        push(8'h43, 1'b0);
        push(8'h44, 1'b0);
        push(8'h45, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_addr", 32'(addr_out), 3);
        chk("pre_rst_data", 32'(w_data_out), 32'h43);
        chk("pre_rst_writes", 32'(got_addr.size()), 4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("wrst_trig",  32'(trig_out), 0);
        chk("wrst_addr",  32'(addr_out), 0);
        chk("wrst_data",  32'(w_data_out), 0);
        chk("wrst_fdone", 32'(frame_done), 0);
        chk("wrst_ready", 32'(pix_ready), 0);
        hold_done = 1'b0;
        n0 = got_addr.size();
        repeat (8) @(negedge clk);
        chk("wrst_flushed", 32'(got_addr.size()), 32'(n0));
        chk("wrst_ready_back", 32'(pix_ready), 1);
        push(8'h77, 1'b0);
        wait_writes(n0 + 1);
        chk("wrst_next_addr", 32'(got_addr[n0]), 0);
        chk("wrst_next_data", 32'(got_data[n0]), 32'h77);

        // random stalls and latencies over three frames
        clear_log();
        fd0 = fd_cnt;
        rand_lat = 1'b1;
        for (int i = 0; i < 24; i++) begin
            exp_d[i] = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(exp_d[i], i == 0);
        end
        wait_writes(24);
        rand_lat = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk("rnd_addr", 32'(got_addr[i]), 32'(i % 8));
            chk("rnd_data", 32'(got_data[i]), 32'(exp_d[i]));
        end
        for (int k = 0; k < FP; k++) chk("rnd_mem", 32'(mem[k]), 32'(exp_d[16 + k]));
        chk("rnd_fd_count", 32'(fd_cnt - fd0), 3);
        chk("rnd_count", 32'(got_addr.size()), 24);

        chk("trig_pulse_width", 32'(dbl_trig), 0);
        chk("wait_outputs_stable", 32'(stable_err), 0);
        chk("rw_const", 32'(rw_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FRAME_PIXELS, default 480000, pixels per frame (800x600); address wraps after FRAME_PIXELS-1.
REQ-002 Parameter FIFO_DEPTH, default 4, input pixel FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 pix_valid  input  1  upstream pixel present.
REQ-006 pix_data  input  8  pixel, packed {blue[2:0], green[1:0], red[2:0]}, stored as-is.
REQ-007 pix_sof  input  1  pixel is the first of a frame; qualified by pix_valid.
REQ-008 pix_ready  output  1  block accepts pixel this cycle.
REQ-009 trig_out  output  1  one-cycle write request to SRAM controller.
REQ-010 rw_out  output  1  transfer direction; constant 0 (write).
REQ-011 addr_out  output  19  SRAM byte address of current write.
REQ-012 w_data_out  output  8  write data of current write.
REQ-013 done_in  input  1  one-cycle pulse from SRAM controller: current write complete.
REQ-014 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.

Function
REQ-015 Accept a pixel when pix_valid and pix_ready are both 1; push {pix_sof, pix_data} into the FIFO.
REQ-016 pix_ready SHALL be 1 when the FIFO is not full, derived from registered FIFO state only; no combinational path from done_in or pix_valid.
REQ-017 FSM states: IDLE, ISSUE, WAIT; register encoded.
REQ-018 IDLE: FIFO non-empty -> ISSUE next cycle; otherwise stay.
REQ-019 ISSUE (exactly one cycle): pop FIFO head; load w_data_out; load addr_out = 0 if popped sof = 1, else write pointer; trig_out = 1; -> WAIT.
REQ-020 WAIT: trig_out = 0; addr_out and w_data_out held stable; on done_in = 1 -> IDLE; otherwise stay.
REQ-021 On done_in in WAIT: write pointer = addr_out + 1, or 0 when addr_out = FRAME_PIXELS-1; frame_done = 1 for that same next cycle only.
REQ-022 done_in in IDLE or ISSUE SHALL be ignored.
REQ-023 sof resync: a popped sof entry forces address 0 regardless of pointer; no frame_done for the truncated frame.
REQ-024 Latency: pixel accepted at edge N with FIFO empty and FSM IDLE -> trig_out = 1 in cycle N+2.
REQ-025 Push while FIFO full is impossible (pix_ready = 0); push and pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-026 Throughput: at most one write per 3 cycles plus controller latency; no pixel dropped or duplicated.
REQ-027 Pointer and address arithmetic 19-bit unsigned; compare against FRAME_PIXELS-1, never relying on natural overflow.

Reset
REQ-028 While rst = 0 at a rising edge: FSM -> IDLE, FIFO flushed (empty), write pointer = 0, addr_out = 0, w_data_out = 0, trig_out = 0, frame_done = 0, pix_ready = 0.
REQ-029 pix_ready SHALL be 1 from the first cycle after rst returns to 1.
REQ-030 Reset asserted during WAIT SHALL abandon the pending write; a later done_in SHALL be ignored (REQ-022).

Verification
REQ-031 Single pixel 0xA5, sof=1, done_in 3 cycles after trig -> trig_out high cycle N+2, addr_out 0, w_data_out 0xA5, next write at address 1.
REQ-032 done_in held 0, pix_valid held 1 -> exactly 5 pixels accepted (1 in flight + 4 FIFO), then pix_ready = 0; releasing done_in drains all 5 in order at addresses 0..4.
REQ-033 FRAME_PIXELS = 8, 9 pixels, done_in 1 cycle after trig -> addresses 0..7 then 0; frame_done pulses once, cycle after done_in of address 7.
REQ-034 sof=1 on 4th pixel of a frame -> writes at 0,1,2,0; no frame_done.
REQ-035 rst = 0 for one cycle during WAIT at address 3 with FIFO holding 2 -> all outputs zero, FIFO empty; next pixel (sof=0) written at address 0.
REQ-036 Random stall on pix_valid and done_in latency 1..10 over 3 frames -> SRAM model contents match input stream, frame_done count = 3.
